// File: rtl/imgmem_write_arbiter.sv
// Write arbiter for the single-port image memory: buffers writer traffic in a
// FIFO and drains it only while video is blanked, so VGA fetches are never displaced.
module imgmem_write_arbiter #(
  parameter int FIFO_DEPTH        = 16,
  parameter bit DRAIN_VBLANK_ONLY = 1'b0
) (
  input  logic        iVGA_CLK,
  input  logic        reset,
  input  logic        iBLANK_n,
  input  logic        iVS,
  input  logic [18:0] vga_addr,
  input  logic        wr_valid,
  input  logic [18:0] wr_addr,
  input  logic [7:0]  wr_data,
  input  logic        hold,
  output logic        wr_full,
  output logic [8:0]  wr_count,
  output logic        overflow,
  output logic [18:0] mem_addr,
  output logic [7:0]  mem_data,
  output logic        mem_wren,
  output logic [15:0] frame_count
);

  localparam int         AW        = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [8:0] DEPTH_CNT = 9'(FIFO_DEPTH);

  logic [18:0]   addr_mem [FIFO_DEPTH];
  logic [7:0]    data_mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [8:0]    count_q, count_d;
  logic          full_q, full_d;
  logic          overflow_q, overflow_d;
  logic          vs_q;
  logic          vblank_q, vblank_d;
  logic [15:0]   frame_q, frame_d;

  logic          vs_fall;
  logic          drain_ok;
  logic          grant;
  logic          push;
  logic          drop;

  always_comb begin
    vs_fall  = vs_q & ~iVS;
    drain_ok = ~iBLANK_n & (DRAIN_VBLANK_ONLY ? vblank_q : 1'b1);
    // Reset gating keeps the memory port on the VGA address while reset is held.
    grant    = drain_ok & ~hold & (count_q != 9'd0) & ~reset;
    push     = wr_valid & (~full_q | grant);
    drop     = wr_valid & full_q & ~grant;

    wr_ptr_d   = wr_ptr_q + AW'(push);
    rd_ptr_d   = rd_ptr_q + AW'(grant);
    count_d    = count_q + 9'(push) - 9'(grant);
    full_d     = (count_d == DEPTH_CNT);
    overflow_d = overflow_q | drop;
    frame_d    = frame_q + 16'(vs_fall);

    vblank_d = vblank_q;
    if (vs_fall) begin
      vblank_d = 1'b1;
    end else if (iBLANK_n) begin
      vblank_d = 1'b0;
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      vs_q       <= 1'b1;
      vblank_q   <= 1'b0;
      frame_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      full_q     <= full_d;
      overflow_q <= overflow_d;
      vs_q       <= iVS;
      vblank_q   <= vblank_d;
      frame_q    <= frame_d;
    end
  end

  // Storage needs no reset: the pointers and occupancy alone define validity.
  always_ff @(posedge iVGA_CLK) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= wr_addr;
      data_mem[wr_ptr_q] <= wr_data;
    end
  end

  always_comb begin
    mem_addr = vga_addr;
    mem_data = 8'h00;
    mem_wren = 1'b0;
    if (grant) begin
      mem_addr = addr_mem[rd_ptr_q];
      mem_data = data_mem[rd_ptr_q];
      mem_wren = 1'b1;
    end
  end

  assign wr_full     = full_q;
  assign wr_count    = count_q;
  assign overflow    = overflow_q;
  assign frame_count = frame_q;

endmodule

// File: tb/tb_imgmem_write_arbiter.sv
// Randomized + directed bench for imgmem_write_arbiter: two instances (drain in any
// blank / drain in vertical blank only) checked against a queue-based reference model.
module tb_imgmem_write_arbiter;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      = 1'b1;
  logic        blank_n  = 1'b1;
  logic        vs       = 1'b1;
  logic [18:0] vga_addr = '0;
  logic        wr_valid = 1'b0;
  logic [18:0] wr_addr  = '0;
  logic [7:0]  wr_data  = '0;
  logic        hold     = 1'b0;

  logic [1:0]  wr_full_w;
  logic [1:0]  overflow_w;
  logic [1:0]  mem_wren_w;
  logic [8:0]  wr_count_w [2];
  logic [18:0] mem_addr_w [2];
  logic [7:0]  mem_data_w [2];
  logic [15:0] frame_w    [2];

  imgmem_write_arbiter #(.FIFO_DEPTH(DEPTH), .DRAIN_VBLANK_ONLY(1'b0)) u_any_blank (
    .iVGA_CLK(clk), .reset(rst), .iBLANK_n(blank_n), .iVS(vs), .vga_addr(vga_addr),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold),
    .wr_full(wr_full_w[0]), .wr_count(wr_count_w[0]), .overflow(overflow_w[0]),
    .mem_addr(mem_addr_w[0]), .mem_data(mem_data_w[0]), .mem_wren(mem_wren_w[0]),
    .frame_count(frame_w[0])
  );

  imgmem_write_arbiter #(.FIFO_DEPTH(DEPTH), .DRAIN_VBLANK_ONLY(1'b1)) u_vblank_only (
    .iVGA_CLK(clk), .reset(rst), .iBLANK_n(blank_n), .iVS(vs), .vga_addr(vga_addr),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .hold(hold),
    .wr_full(wr_full_w[1]), .wr_count(wr_count_w[1]), .overflow(overflow_w[1]),
    .mem_addr(mem_addr_w[1]), .mem_data(mem_data_w[1]), .mem_wren(mem_wren_w[1]),
    .frame_count(frame_w[1])
  );

  // Reference model: pending writes as a queue of {addr,data}, plus frame/vblank state.
  logic [26:0] mq   [2][$];
  logic [26:0] expq [2][$];
  logic        movf   [2];
  logic [15:0] mframe [2];
  logic        mvs    [2];
  logic        mvb    [2];

  int passes = 0;
  int total  = 0;
  bit started = 1'b0;
  bit done    = 1'b0;

  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passes++;
    end else begin
      $display("FAIL %s[inst%0d] t=%0t got %0h expected %0h", nm, k, $time, act, exp);
    end
  endtask

  task automatic model_reset(input int k);
    mq[k].delete();
    movf[k]   = 1'b0;
    mframe[k] = 16'd0;
    mvs[k]    = 1'b1;
    mvb[k]    = 1'b0;
  endtask

  // One clock cycle: check registered outputs, drive inputs, advance the model.
  task automatic cyc(input logic bn, input logic v, input logic h, input logic wv, input logic r);
    logic drain;
    logic g;
    @(negedge clk);
    if (started) begin
      for (int k = 0; k < 2; k++) begin
        chk("wr_count",    k, 32'(wr_count_w[k]), 32'(mq[k].size()));
        chk("wr_full",     k, 32'(wr_full_w[k]),  32'(mq[k].size() == DEPTH));
        chk("overflow",    k, 32'(overflow_w[k]), 32'(movf[k]));
        chk("frame_count", k, 32'(frame_w[k]),    32'(mframe[k]));
      end
    end
    rst      = r;
    blank_n  = bn;
    vs       = v;
    hold     = h;
    wr_valid = wv;
    wr_addr  = ($urandom_range(0, 3) == 0) ? 19'h00005 : 19'($urandom);
    wr_data  = 8'($urandom);
    vga_addr = 19'($urandom);
    for (int k = 0; k < 2; k++) begin
      drain = ~bn & ((k == 0) ? 1'b1 : mvb[k]);
      g     = drain & ~h & (mq[k].size() != 0) & ~r;
      if (g) expq[k].push_back(mq[k][0]);
      if (r) begin
        model_reset(k);
      end else begin
        if (g) void'(mq[k].pop_front());
        if (wv) begin
          if (mq[k].size() < DEPTH) mq[k].push_back({wr_addr, wr_data});
          else                      movf[k] = 1'b1;
        end
        if (mvs[k] && !v) begin
          mframe[k] = mframe[k] + 16'd1;
          mvb[k]    = 1'b1;
        end else if (bn) begin
          mvb[k] = 1'b0;
        end
        mvs[k] = v;
      end
    end
    if (r) started = 1'b1;
  endtask

  // Monitor: compares the memory port against the scoreboard every cycle.
  initial begin
    logic [26:0] e;
    forever begin
      @(negedge clk);
      if (done) break;
      #2;
      for (int k = 0; k < 2; k++) begin
        if (mem_wren_w[k]) begin
          if (expq[k].size() == 0) begin
            chk("unexpected_wren", k, 32'(mem_wren_w[k]), 32'd0);
          end else begin
            e = expq[k].pop_front();
            chk("write", k, {5'b0, mem_addr_w[k], mem_data_w[k]}, {5'b0, e});
          end
        end else if (expq[k].size() != 0) begin
          e = expq[k].pop_front();
          chk("missing_write", k, 32'(mem_wren_w[k]), 32'd1);
        end else begin
          chk("idle_port", k, {5'b0, mem_addr_w[k], mem_data_w[k]}, {5'b0, vga_addr, 8'h00});
        end
      end
    end
  end

  initial begin
    logic rb;
    logic rv;
    int   dens;
    for (int k = 0; k < 2; k++) model_reset(k);

    // Reset, then 3 pushes during active video.
    repeat (2) cyc(1, 1, 0, 0, 1);
    repeat (3) cyc(1, 1, 0, 1, 0);
    // Two blank cycles drain two entries (any-blank instance only).
    repeat (2) cyc(0, 1, 0, 0, 0);
    repeat (3) cyc(1, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    // Overfill: 17 pushes in active video, then push+pop while full in blank.
    repeat (17) cyc(1, 1, 0, 1, 0);
    repeat (3)  cyc(0, 1, 0, 1, 0);
    // H-blank only with VS high, then a VS falling edge inside blank.
    repeat (4) begin
      repeat (6) cyc(1, 1, 0, 0, 0);
      repeat (4) cyc(0, 1, 0, 0, 0);
    end
    repeat (3) cyc(0, 0, 0, 0, 0);
    repeat (5) cyc(1, 0, 0, 0, 0);
    repeat (3) cyc(0, 1, 0, 0, 0);
    // Hold through a 100-cycle blank with 5 queued, then release mid-blank.
    cyc(1, 1, 0, 0, 1);
    repeat (5)  cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 1, 0, 0);
    repeat (99) cyc(0, 1, 1, 0, 0);
    repeat (6)  cyc(0, 1, 0, 0, 0);
    // Reset while draining with 4 queued.
    cyc(1, 1, 0, 0, 1);
    repeat (4) cyc(1, 1, 0, 1, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 0);
    cyc(0, 1, 0, 0, 1);
    repeat (4) cyc(0, 1, 0, 0, 0);

    // Randomized traffic with varying push density.
    rb = 1'b1;
    rv = 1'b1;
    for (int seg = 0; seg < 20; seg++) begin
      dens = $urandom_range(1, 9);
      repeat (200) begin
        if ($urandom_range(0, 7) == 0)  rb = ~rb;
        if ($urandom_range(0, 40) == 0) rv = ~rv;
        cyc(rb, rv, ($urandom_range(0, 5) == 0), ($urandom_range(0, 9) < dens),
            ($urandom_range(0, 799) == 0));
      end
    end

    repeat (3) cyc(1, 1, 0, 0, 0);
    #3;
    done = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("pending_writes", k, 32'(expq[k].size()), 32'd0);
    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

endmodule
